// File: rtl/action_exec_pkg.sv
// Shared types and constants for the action execution stage: opcodes, FSM states,
// action-record byte layout and the saturating counter helper.
package action_exec_pkg;

    localparam int HDR_MAX_LEN_DEF = 64;
    localparam int MAX_VAL_LEN_DEF = 16;
    localparam int NUM_HEADERS_DEF = 8;
    localparam int PORT_W_DEF      = 8;

    // Byte positions inside the flow value record
    localparam int REC_OP   = 0;
    localparam int REC_HDR  = 1;
    localparam int REC_OFF  = 2;
    localparam int REC_LEN  = 3;
    localparam int REC_DATA = 4;

    localparam int DATA_CAP = MAX_VAL_LEN_DEF - REC_DATA;

    typedef enum logic [7:0] {
        OP_NOP  = 8'd0,
        OP_SET  = 8'd1,
        OP_DROP = 8'd2,
        OP_FWD  = 8'd3,
        OP_DEC  = 8'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_WRITE,
        S_DONE
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/action_decode.sv
// Combinational action-record decoder: validity, target base address, clamped
// length and the verdict/port chosen before any header byte is touched.
module action_decode
    import action_exec_pkg::*;
#(
    parameter int NUM_HEADERS = NUM_HEADERS_DEF,
    parameter int PORT_W      = PORT_W_DEF,
    parameter int CAP         = DATA_CAP
) (
    input  logic                     hit_i,
    input  logic [7:0]               op_i,
    input  logic [3:0]               hdr_id_i,
    input  logic [7:0]               off_i,
    input  logic [7:0]               len_i,
    input  logic [7:0]               arg_i,
    input  logic [32*NUM_HEADERS-1:0] parsed_hdrs_i,
    input  logic                     def_drop_i,
    input  logic [PORT_W-1:0]        def_port_i,
    output logic                     opcode_valid_o,
    output logic [31:0]              target_base_o,
    output logic [7:0]               len_clamped_o,
    output logic                     drop_o,
    output logic [PORT_W-1:0]        port_o
);
    localparam int HW = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;

    logic          hdr_ok;
    logic [HW-1:0] hdr_sel;

    // A header id beyond the offset table is malformed, like an unknown opcode
    assign hdr_ok         = 32'(hdr_id_i) < 32'(NUM_HEADERS);
    assign hdr_sel        = hdr_ok ? hdr_id_i[HW-1:0] : '0;
    assign opcode_valid_o = hdr_ok && (op_i <= 8'(OP_DEC));
    assign target_base_o  = parsed_hdrs_i[32*hdr_sel +: 32] + {24'd0, off_i};
    assign len_clamped_o  = (32'(len_i) > 32'(CAP)) ? 8'(CAP) : len_i;

    always_comb begin
        drop_o = 1'b0;
        port_o = def_port_i;
        if (!hit_i) begin
            drop_o = def_drop_i;
        end else if (opcode_valid_o) begin
            case (op_i)
                8'(OP_DROP): drop_o = 1'b1;
                8'(OP_FWD):  port_o = PORT_W'(arg_i);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/action_exec.sv
// Action execution stage: applies a matched flow's action record to a header copy.
// Define ACTION_STATS_EN to add saturating hit/miss/drop counters.
module action_exec
    import action_exec_pkg::*;
#(
    parameter int HDR_MAX_LEN = HDR_MAX_LEN_DEF,
    parameter int MAX_VAL_LEN = MAX_VAL_LEN_DEF,
    parameter int NUM_HEADERS = NUM_HEADERS_DEF,
    parameter int PORT_W      = PORT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      match_ready_i,
    input  logic                      match_is_match_i,
    input  logic [8*MAX_VAL_LEN-1:0]  flow_val_i,
    input  logic [8*HDR_MAX_LEN-1:0]  pkt_hdr_i,
    input  logic [32*NUM_HEADERS-1:0] parsed_hdrs_i,
    input  logic                      mod_start_i,
    input  logic                      mod_def_drop_i,
    input  logic [PORT_W-1:0]         mod_def_port_i,
    output logic                      idle_o,
    output logic                      ready_o,
    output logic                      drop_o,
    output logic [PORT_W-1:0]         egress_port_o,
    output logic [8*HDR_MAX_LEN-1:0]  pkt_hdr_o,
    output logic                      err_o
`ifdef ACTION_STATS_EN
   ,output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o,
    output logic [31:0]               drop_cnt_o
`endif
);
    localparam int AW = $clog2(HDR_MAX_LEN);
    localparam int VW = $clog2(MAX_VAL_LEN);

    state_e                    state_q;
    logic                      hit_q;
    logic [8*MAX_VAL_LEN-1:0]  flow_q;
    logic [8*HDR_MAX_LEN-1:0]  hdr_q;
    logic [32*NUM_HEADERS-1:0] parsed_q;
    logic                      cfg_drop_q;
    logic [PORT_W-1:0]         cfg_port_q;
    logic                      is_dec_q;
    logic [31:0]               base_q;
    logic [7:0]                cnt_q;
    logic [7:0]                idx_q;
    logic                      ovf_q;
    logic                      drop_w_q;
    logic [PORT_W-1:0]         port_w_q;
    logic                      ready_q;
    logic                      drop_q;
    logic [PORT_W-1:0]         port_q;
    logic [8*HDR_MAX_LEN-1:0]  hdr_out_q;
    logic                      err_q;
`ifdef ACTION_STATS_EN
    logic [31:0]               hit_cnt_q;
    logic [31:0]               miss_cnt_q;
    logic [31:0]               drop_cnt_q;
`endif

    logic                      dec_valid;
    logic [31:0]               dec_base;
    logic [7:0]                dec_len;
    logic                      dec_drop;
    logic [PORT_W-1:0]         dec_port;
    logic [7:0]                dec_op;
    logic                      dec_go_write;

    logic [31:0]               wr_addr;
    logic                      wr_in_range;
    logic [AW+2:0]             wr_bit;
    logic [VW+2:0]             dat_bit;
    logic [7:0]                cur_byte;
    logic [7:0]                wr_data;
    logic                      unused_rec;

    assign dec_op = flow_q[8*REC_OP +: 8];

    action_decode #(
        .NUM_HEADERS (NUM_HEADERS),
        .PORT_W      (PORT_W),
        .CAP         (MAX_VAL_LEN - REC_DATA)
    ) u_decode (
        .hit_i          (hit_q),
        .op_i           (dec_op),
        .hdr_id_i       (flow_q[8*REC_HDR +: 4]),
        .off_i          (flow_q[8*REC_OFF +: 8]),
        .len_i          (flow_q[8*REC_LEN +: 8]),
        .arg_i          (flow_q[8*REC_DATA +: 8]),
        .parsed_hdrs_i  (parsed_q),
        .def_drop_i     (cfg_drop_q),
        .def_port_i     (cfg_port_q),
        .opcode_valid_o (dec_valid),
        .target_base_o  (dec_base),
        .len_clamped_o  (dec_len),
        .drop_o         (dec_drop),
        .port_o         (dec_port)
    );

    // Upper nibble of the hdr_id byte carries no meaning
    assign unused_rec = ^flow_q[8*REC_HDR+4 +: 4];

    assign dec_go_write = hit_q && dec_valid &&
                          ((dec_op == 8'(OP_SET) && dec_len != 8'd0) || dec_op == 8'(OP_DEC));

    assign wr_addr     = base_q + {24'd0, idx_q};
    assign wr_in_range = wr_addr < 32'(HDR_MAX_LEN);
    assign wr_bit      = {wr_addr[AW-1:0], 3'b000};
    assign dat_bit     = {idx_q[VW-1:0] + VW'(REC_DATA), 3'b000};
    assign cur_byte    = hdr_q[wr_bit +: 8];
    assign wr_data     = flow_q[dat_bit +: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hit_q      <= 1'b0;
            flow_q     <= '0;
            hdr_q      <= '0;
            parsed_q   <= '0;
            cfg_drop_q <= 1'b1;
            cfg_port_q <= '0;
            is_dec_q   <= 1'b0;
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            drop_w_q   <= 1'b0;
            port_w_q   <= '0;
            ready_q    <= 1'b0;
            drop_q     <= 1'b0;
            port_q     <= '0;
            hdr_out_q  <= '0;
            err_q      <= 1'b0;
`ifdef ACTION_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            drop_cnt_q <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mod_start_i) begin
                        // Config update wins over a coincident match
                        cfg_drop_q <= mod_def_drop_i;
                        cfg_port_q <= mod_def_port_i;
                        if (match_ready_i) err_q <= 1'b1;
                    end else if (match_ready_i) begin
                        hit_q    <= match_is_match_i;
                        flow_q   <= flow_val_i;
                        hdr_q    <= pkt_hdr_i;
                        parsed_q <= parsed_hdrs_i;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (match_ready_i) err_q <= 1'b1;
                    if (hit_q && !dec_valid) err_q <= 1'b1;
                    base_q   <= dec_base;
                    is_dec_q <= (dec_op == 8'(OP_DEC));
                    cnt_q    <= (dec_op == 8'(OP_DEC)) ? 8'd1 : dec_len;
                    idx_q    <= '0;
                    ovf_q    <= 1'b0;
                    drop_w_q <= dec_drop;
                    port_w_q <= dec_port;
                    state_q  <= dec_go_write ? S_WRITE : S_DONE;
                end
                S_WRITE: begin
                    if (match_ready_i) err_q <= 1'b1;
                    if (wr_in_range) begin
                        if (is_dec_q) begin
                            hdr_q[wr_bit +: 8] <= cur_byte - 8'd1;
                            if (cur_byte == 8'd1) drop_w_q <= 1'b1;
                        end else begin
                            hdr_q[wr_bit +: 8] <= wr_data;
                        end
                    end else if (!ovf_q) begin
                        ovf_q <= 1'b1;
                        err_q <= 1'b1;
                    end
                    idx_q <= idx_q + 8'd1;
                    if (idx_q == cnt_q - 8'd1) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (match_ready_i) err_q <= 1'b1;
                    hdr_out_q <= hdr_q;
                    drop_q    <= drop_w_q;
                    port_q    <= port_w_q;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
`ifdef ACTION_STATS_EN
                    if (hit_q) hit_cnt_q <= sat_inc(hit_cnt_q);
                    else       miss_cnt_q <= sat_inc(miss_cnt_q);
                    if (drop_w_q) drop_cnt_q <= sat_inc(drop_cnt_q);
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign idle_o        = (state_q == S_IDLE);
    assign ready_o       = ready_q;
    assign drop_o        = drop_q;
    assign egress_port_o = port_q;
    assign pkt_hdr_o     = hdr_out_q;
    assign err_o         = err_q;
`ifdef ACTION_STATS_EN
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_action_exec.sv
// Self-checking bench for action_exec: directed scenarios plus randomized
// actions against a byte-level reference model.
module tb_action_exec;
    localparam int HL = 64;
    localparam int VL = 16;
    localparam int NH = 8;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              match_ready_i = 1'b0;
    logic              match_is_match_i = 1'b0;
    logic [8*VL-1:0]   flow_val_i = '0;
    logic [8*HL-1:0]   pkt_hdr_i = '0;
    logic [32*NH-1:0]  parsed_hdrs_i = '0;
    logic              mod_start_i = 1'b0;
    logic              mod_def_drop_i = 1'b0;
    logic [PW-1:0]     mod_def_port_i = '0;
    logic              idle_o, ready_o, drop_o, err_o;
    logic [PW-1:0]     egress_port_o;
    logic [8*HL-1:0]   pkt_hdr_o;
`ifdef ACTION_STATS_EN
    logic [31:0]       hit_cnt_o, miss_cnt_o, drop_cnt_o;
`endif

    action_exec dut (
        .clk(clk), .rst(rst),
        .match_ready_i(match_ready_i), .match_is_match_i(match_is_match_i),
        .flow_val_i(flow_val_i), .pkt_hdr_i(pkt_hdr_i), .parsed_hdrs_i(parsed_hdrs_i),
        .mod_start_i(mod_start_i), .mod_def_drop_i(mod_def_drop_i), .mod_def_port_i(mod_def_port_i),
        .idle_o(idle_o), .ready_o(ready_o), .drop_o(drop_o), .egress_port_o(egress_port_o),
        .pkt_hdr_o(pkt_hdr_o), .err_o(err_o)
`ifdef ACTION_STATS_EN
       ,.hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic          cfg_drop_m = 1'b1;
    logic [PW-1:0] cfg_port_m = '0;

    function automatic logic [8*HL-1:0] rand_hdr();
        logic [8*HL-1:0] h;
        for (int i = 0; i < HL; i++) h[8*i +: 8] = 8'($urandom);
        return h;
    endfunction

    function automatic logic [8*VL-1:0] mk_rec(input logic [7:0] op, input logic [7:0] id,
                                               input logic [7:0] off, input logic [7:0] len);
        logic [8*VL-1:0] f;
        for (int i = 0; i < VL; i++) f[8*i +: 8] = 8'($urandom);
        f[7:0] = op; f[15:8] = id; f[23:16] = off; f[31:24] = len;
        return f;
    endfunction

    // Drives one match and waits for ready_o; lat is 0 if it never arrives.
    task automatic do_action(input logic hit, input logic [8*VL-1:0] fv, input logic [8*HL-1:0] hdr,
                             input logic [32*NH-1:0] ph, output int lat, output int errs);
        @(negedge clk);
        match_ready_i = 1'b1; match_is_match_i = hit;
        flow_val_i = fv; pkt_hdr_i = hdr; parsed_hdrs_i = ph;
        lat = 0; errs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            match_ready_i = 1'b0;
            pkt_hdr_i = ~hdr; flow_val_i = ~fv;
            if (err_o) errs++;
            if (ready_o) begin lat = k; break; end
        end
    endtask

    task automatic set_cfg(input logic d, input logic [PW-1:0] p);
        @(negedge clk);
        mod_start_i = 1'b1; mod_def_drop_i = d; mod_def_port_i = p;
        @(negedge clk);
        mod_start_i = 1'b0;
        cfg_drop_m = d; cfg_port_m = p;
    endtask

    // Reference: applies the action rules byte by byte to the header.
    task automatic model(input logic hit, input logic [8*VL-1:0] fv, input logic [8*HL-1:0] hdr,
                         input logic [32*NH-1:0] ph, output logic [8*HL-1:0] eh, output logic ed,
                         output logic [PW-1:0] ep, output int elat, output int eerr);
        int n;
        int id;
        logic [31:0] base, a;
        logic ovf;
        ovf = 1'b0;
        eh = hdr; ed = cfg_drop_m; ep = cfg_port_m; elat = 3; eerr = 0;
        if (hit) begin
            ed = 1'b0;
            n = (int'(fv[31:24]) > VL - 4) ? VL - 4 : int'(fv[31:24]);
            id = int'(fv[11:8]);
            base = ph[32*id +: 32] + 32'(fv[23:16]);
            case (fv[7:0])
                8'd0: ;
                8'd1: begin
                    for (int i = 0; i < n; i++) begin
                        a = base + 32'(i);
                        if (a < HL) eh[8*a +: 8] = fv[8*(4+i) +: 8];
                        else ovf = 1'b1;
                    end
                    elat = 3 + n;
                end
                8'd2: ed = 1'b1;
                8'd3: ep = fv[39:32];
                8'd4: begin
                    elat = 4;
                    if (base < HL) begin
                        eh[8*base +: 8] = eh[8*base +: 8] - 8'd1;
                        ed = (eh[8*base +: 8] == 8'd0);
                    end else ovf = 1'b1;
                end
                default: eerr = 1;
            endcase
            if (ovf) eerr = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready_o, drop_o, err_o, idle_o} !== 4'b0001 || egress_port_o !== '0 || pkt_hdr_o !== '0) begin
            failures++;
            $display("FAIL reset: ready=%b drop=%b err=%b idle=%b port=%h hdr=%h, want 0 0 0 1 00 0",
                     ready_o, drop_o, err_o, idle_o, egress_port_o, pkt_hdr_o);
        end
        rst = 1'b1;
        cfg_drop_m = 1'b1; cfg_port_m = '0;
    endtask

    task automatic test_miss();
        logic [8*HL-1:0] h;
        int lat, errs;
        h = rand_hdr();
        do_action(1'b0, mk_rec(8'd1, 8'd0, 8'd0, 8'd4), h, '0, lat, errs);
        checks++;
        if (lat !== 3 || drop_o !== 1'b1 || egress_port_o !== 8'h00 || pkt_hdr_o !== h || errs !== 0) begin
            failures++;
            $display("FAIL miss_default: lat=%0d drop=%b port=%h errs=%0d hdr_ok=%b, want 3 1 00 0 1",
                     lat, drop_o, egress_port_o, errs, pkt_hdr_o === h);
        end
    endtask

    task automatic test_set();
        logic [8*HL-1:0] h, e;
        logic [8*VL-1:0] f;
        logic [32*NH-1:0] ph;
        int lat, errs;
        h = rand_hdr(); ph = '0; ph[32*1 +: 32] = 32'd14;
        f = mk_rec(8'd1, 8'd1, 8'd2, 8'd4);
        f[39:32] = 8'hDE; f[47:40] = 8'hAD; f[55:48] = 8'hBE; f[63:56] = 8'hEF;
        e = h; e[8*16 +: 8] = 8'hDE; e[8*17 +: 8] = 8'hAD; e[8*18 +: 8] = 8'hBE; e[8*19 +: 8] = 8'hEF;
        do_action(1'b1, f, h, ph, lat, errs);
        checks++;
        if (lat !== 7 || drop_o !== 1'b0 || pkt_hdr_o !== e || errs !== 0) begin
            failures++;
            $display("FAIL set_basic: lat=%0d drop=%b errs=%0d hdr=%h, want 7 0 0 hdr=%h", lat, drop_o, errs, pkt_hdr_o, e);
        end
    endtask

    task automatic test_dec();
        logic [8*HL-1:0] h, e;
        logic [32*NH-1:0] ph;
        logic [7:0] vin [2];
        logic [7:0] vout [2];
        logic       dexp [2];
        int lat, errs;
        vin[0] = 8'h01; vout[0] = 8'h00; dexp[0] = 1'b1;
        vin[1] = 8'h00; vout[1] = 8'hFF; dexp[1] = 1'b0;
        ph = '0; ph[31:0] = 32'd20;
        for (int t = 0; t < 2; t++) begin
            h = rand_hdr(); h[8*22 +: 8] = vin[t];
            e = h; e[8*22 +: 8] = vout[t];
            do_action(1'b1, mk_rec(8'd4, 8'd0, 8'd2, 8'd0), h, ph, lat, errs);
            checks++;
            if (lat !== 4 || drop_o !== dexp[t] || pkt_hdr_o !== e || errs !== 0) begin
                failures++;
                $display("FAIL dec_%0d: lat=%0d drop=%b byte22=%h errs=%0d, want 4 %b %h 0",
                         t, lat, drop_o, pkt_hdr_o[8*22 +: 8], errs, dexp[t], vout[t]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [8*HL-1:0] h, e;
        logic [8*VL-1:0] f;
        logic [32*NH-1:0] ph;
        int lat, errs;
        h = rand_hdr(); ph = '0; ph[32*3 +: 32] = 32'd60;
        f = mk_rec(8'd1, 8'd3, 8'd2, 8'd4);
        e = h; e[8*62 +: 8] = f[39:32]; e[8*63 +: 8] = f[47:40];
        do_action(1'b1, f, h, ph, lat, errs);
        checks++;
        if (lat !== 7 || pkt_hdr_o !== e || errs !== 1) begin
            failures++;
            $display("FAIL overrun: lat=%0d errs=%0d hdr_ok=%b, want 7 1 1", lat, errs, pkt_hdr_o === e);
        end
    endtask

    task automatic test_cfg();
        int lat, errs;
        logic rdy;
        set_cfg(1'b0, 8'h5A);
        do_action(1'b0, mk_rec(8'd2, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        checks++;
        if (lat !== 3 || drop_o !== 1'b0 || egress_port_o !== 8'h5A) begin
            failures++;
            $display("FAIL cfg_miss: lat=%0d drop=%b port=%h, want 3 0 5a", lat, drop_o, egress_port_o);
        end
        // Config strobe together with a match: config taken, match refused
        @(negedge clk);
        mod_start_i = 1'b1; mod_def_drop_i = 1'b1; mod_def_port_i = 8'h33;
        match_ready_i = 1'b1; match_is_match_i = 1'b0;
        errs = 0; rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mod_start_i = 1'b0; match_ready_i = 1'b0;
            if (err_o) errs++;
            if (ready_o) rdy = 1'b1;
        end
        cfg_drop_m = 1'b1; cfg_port_m = 8'h33;
        checks++;
        if (errs !== 1 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL cfg_collide: errs=%0d ready_seen=%b, want 1 0", errs, rdy);
        end
        do_action(1'b0, mk_rec(8'd0, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        checks++;
        if (drop_o !== 1'b1 || egress_port_o !== 8'h33) begin
            failures++;
            $display("FAIL cfg_after_collide: drop=%b port=%h, want 1 33", drop_o, egress_port_o);
        end
    endtask

    task automatic test_random();
        logic [8*HL-1:0] h, eh;
        logic [8*VL-1:0] f;
        logic [32*NH-1:0] ph;
        logic hit, ed;
        logic [PW-1:0] ep;
        logic [7:0] op;
        int lat, errs, elat, eerr;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 5) == 0) set_cfg(1'($urandom), 8'($urandom));
            for (int j = 0; j < NH; j++)
                ph[32*j +: 32] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 58));
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
            f = mk_rec(op, {4'($urandom), 1'b0, 3'($urandom)}, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 15)));
            hit = ($urandom_range(0, 3) != 0);
            h = rand_hdr();
            model(hit, f, h, ph, eh, ed, ep, elat, eerr);
            do_action(hit, f, h, ph, lat, errs);
            checks++;
            if (lat !== elat || drop_o !== ed || egress_port_o !== ep || pkt_hdr_o !== eh ||
                errs !== eerr || idle_o !== 1'b1) begin
                failures++;
                $display("FAIL random_%0d op=%h hit=%b: lat=%0d drop=%b port=%h errs=%0d hdr_ok=%b idle=%b, want %0d %b %h %0d 1 1",
                         it, op, hit, lat, drop_o, egress_port_o, errs, pkt_hdr_o === eh, idle_o, elat, ed, ep, eerr);
            end
        end
    endtask

    task automatic test_busy_and_reset();
        logic [8*HL-1:0] h, e;
        logic [8*VL-1:0] f;
        int lat, errs;
        logic rdy;
        h = rand_hdr();
        f = mk_rec(8'd1, 8'd0, 8'd0, 8'd8);
        e = h;
        for (int i = 0; i < 8; i++) e[8*i +: 8] = f[8*(4+i) +: 8];
        @(negedge clk);
        match_ready_i = 1'b1; match_is_match_i = 1'b1; flow_val_i = f; pkt_hdr_i = h; parsed_hdrs_i = '0;
        lat = 0; errs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            match_ready_i = (k == 3);
            if (err_o) errs++;
            if (ready_o) begin lat = k; break; end
        end
        checks++;
        if (lat !== 11 || errs !== 1 || pkt_hdr_o !== e) begin
            failures++;
            $display("FAIL busy_match: lat=%0d errs=%0d hdr_ok=%b, want 11 1 1", lat, errs, pkt_hdr_o === e);
        end
        @(negedge clk);
        match_ready_i = 1'b1; match_is_match_i = 1'b1;
        repeat (4) @(negedge clk) match_ready_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_o, drop_o, err_o, idle_o} !== 4'b0001 || egress_port_o !== '0 || pkt_hdr_o !== '0) begin
            failures++;
            $display("FAIL mid_reset: ready=%b drop=%b err=%b idle=%b port=%h, want 0 0 0 1 00 hdr 0",
                     ready_o, drop_o, err_o, idle_o, egress_port_o);
        end
        rst = 1'b1;
        cfg_drop_m = 1'b1; cfg_port_m = '0;
        rdy = 1'b0;
        repeat (15) @(negedge clk) if (ready_o) rdy = 1'b1;
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ready: ready seen=%b, want 0", rdy);
        end
    endtask

`ifdef ACTION_STATS_EN
    task automatic test_stats();
        int lat, errs;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cfg_drop_m = 1'b1; cfg_port_m = '0;
        checks++;
        if (hit_cnt_o !== 0 || miss_cnt_o !== 0 || drop_cnt_o !== 0) begin
            failures++;
            $display("FAIL stats_reset: %0d %0d %0d, want 0 0 0", hit_cnt_o, miss_cnt_o, drop_cnt_o);
        end
        do_action(1'b1, mk_rec(8'd0, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        do_action(1'b0, mk_rec(8'd0, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        do_action(1'b1, mk_rec(8'd2, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        do_action(1'b0, mk_rec(8'd3, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        do_action(1'b1, mk_rec(8'd3, 8'd0, 8'd0, 8'd0), rand_hdr(), '0, lat, errs);
        checks++;
        if (hit_cnt_o !== 3 || miss_cnt_o !== 2 || drop_cnt_o !== 3) begin
            failures++;
            $display("FAIL stats: hit=%0d miss=%0d drop=%0d, want 3 2 3", hit_cnt_o, miss_cnt_o, drop_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_miss();
        test_set();
        test_dec();
        test_overrun();
        test_cfg();
        test_random();
        test_busy_and_reset();
`ifdef ACTION_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
